// File: rtl/tx_seg_issue.sv
// Send-side segment issuer for one TCP flow: sizes segments from buffered data
// and peer window, offers {ptr,size} descriptors over val/rdy, owns trail_ptr.
module tx_seg_issue #(
    parameter int unsigned PTR_W        = 12,
    parameter int unsigned MAX_SEG_SIZE = 1440,
    parameter int unsigned COALESCE_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PTR_W:0]   lead_ptr,
    input  logic [PTR_W:0]   ack_ptr,
    input  logic [15:0]      peer_wnd,
    input  logic             flush,
    input  logic             ptr_load_val,
    input  logic [PTR_W:0]   ptr_load_ptr,
    output logic [PTR_W:0]   trail_ptr,
    output logic             seg_req_val,
    input  logic             seg_req_rdy,
    output logic [PTR_W:0]   seg_req_ptr,
    output logic [PTR_W:0]   seg_req_size
);

    localparam int unsigned PW       = PTR_W + 1;
    localparam int unsigned BUF_SIZE = 2 ** PTR_W;
    localparam int unsigned CNT_W    = $clog2(COALESCE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0]    r_trail, w_trail_nxt;
    logic             r_val, w_val_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [PW-1:0]    r_size, w_size_nxt;

    // Input stage: sizing sees lead/ack/window one cycle late, which only ever
    // under-estimates usable bytes, so the invariant seg size <= avail holds.
    logic [PW-1:0]    r_lead, r_ack;
    logic [15:0]      r_wnd;

    logic [PW-1:0]    w_avail, w_win_raw, w_win, w_u, w_size;
    logic             w_small;

    assign w_avail   = r_lead - r_trail;
    assign w_win_raw = r_ack + PW'(r_wnd) - r_trail;
    assign w_win     = (w_win_raw > PW'(BUF_SIZE)) ? '0 : w_win_raw;
    assign w_u       = (w_avail < w_win) ? w_avail : w_win;
    assign w_small   = (w_u < PW'(32));

    always_comb begin
        if (w_u > PW'(MAX_SEG_SIZE)) begin
            w_size = PW'(MAX_SEG_SIZE);
        end else if (w_small) begin
            w_size = w_u;
        end else begin
            w_size = {w_u[PW-1:5], 5'b0};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_trail_nxt = r_trail;
        w_val_nxt   = r_val;
        w_ptr_nxt   = r_ptr;
        w_size_nxt  = r_size;
        unique case (r_state)
            IDLE: begin
                w_val_nxt = 1'b0;
                if (w_u != '0) begin
                    if (w_small && !flush) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_ptr_nxt   = r_trail;
                        w_size_nxt  = w_size;
                        w_val_nxt   = 1'b1;
                    end
                end
            end
            HOLD: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_u == '0) begin
                    w_state_nxt = IDLE;
                end else if (!w_small || flush || (r_cnt == CNT_W'(COALESCE_CYC - 1))) begin
                    w_state_nxt = ISSUE;
                    w_ptr_nxt   = r_trail;
                    w_size_nxt  = w_size;
                    w_val_nxt   = 1'b1;
                end
            end
            ISSUE: begin
                w_val_nxt = 1'b1;
                if (seg_req_rdy) begin
                    w_trail_nxt = r_trail + r_size;
                    w_val_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_val_nxt   = 1'b0;
            end
        endcase
        // Reload wins over everything, including a same-cycle handshake.
        if (ptr_load_val) begin
            w_trail_nxt = ptr_load_ptr;
            w_state_nxt = IDLE;
            w_val_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_trail <= '0;
            r_val   <= 1'b0;
            r_ptr   <= '0;
            r_size  <= '0;
            r_lead  <= '0;
            r_ack   <= '0;
            r_wnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_trail <= w_trail_nxt;
            r_val   <= w_val_nxt;
            r_ptr   <= w_ptr_nxt;
            r_size  <= w_size_nxt;
            r_lead  <= lead_ptr;
            r_ack   <= ack_ptr;
            r_wnd   <= peer_wnd;
        end
    end

    assign trail_ptr    = r_trail;
    assign seg_req_val  = r_val;
    assign seg_req_ptr  = r_ptr;
    assign seg_req_size = r_size;

endmodule

// File: tb/tb_tx_seg_issue.sv
// Directed bench for tx_seg_issue: vector table of single-segment cases plus
// hand-written sequences for coalescing, wrap, backpressure and reload.
module tb_tx_seg_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] lead_ptr, ack_ptr, ptr_load_ptr;
    logic [15:0] peer_wnd;
    logic        flush, ptr_load_val, seg_req_rdy;
    logic [12:0] trail_ptr, seg_req_ptr, seg_req_size;
    logic        seg_req_val;

    int n_vec = 0;
    int n_err = 0;

    tx_seg_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lead_ptr     (lead_ptr),
        .ack_ptr      (ack_ptr),
        .peer_wnd     (peer_wnd),
        .flush        (flush),
        .ptr_load_val (ptr_load_val),
        .ptr_load_ptr (ptr_load_ptr),
        .trail_ptr    (trail_ptr),
        .seg_req_val  (seg_req_val),
        .seg_req_rdy  (seg_req_rdy),
        .seg_req_ptr  (seg_req_ptr),
        .seg_req_size (seg_req_size)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    typedef struct {
        logic [12:0] lead;
        logic [12:0] ack;
        logic [15:0] wnd;
        logic        fl;
        int          exp_size;  // 0: no segment may be offered
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        lead_ptr     = '0;
        ack_ptr      = '0;
        peer_wnd     = 16'd4096;
        flush        = 1'b0;
        ptr_load_val = 1'b0;
        ptr_load_ptr = '0;
        seg_req_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Counts rising edges until val is seen (sampled 1 time unit after the edge).
    task automatic wait_val(input int max_cyc, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (seg_req_val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept();
        seg_req_rdy = 1'b1;
        @(posedge clk);
        #1;
        seg_req_rdy = 1'b0;
    endtask

    vec_t vecs[12];
    int   cyc;
    bit   ok;
    int   exp_trail;
    int   sizes[5];
    int   p0, s0;

    initial begin
        vecs[0]  = '{13'd100,  13'd0,    16'd4096, 1'b0, 96,   2};
        vecs[1]  = '{13'd5000, 13'd0,    16'd4096, 1'b0, 1440, 2};
        vecs[2]  = '{13'd2000, 13'd0,    16'd100,  1'b0, 96,   2};
        vecs[3]  = '{13'd31,   13'd0,    16'd4096, 1'b1, 31,   2};
        vecs[4]  = '{13'd32,   13'd0,    16'd4096, 1'b0, 32,   2};
        vecs[5]  = '{13'd1440, 13'd0,    16'd4096, 1'b0, 1440, 2};
        vecs[6]  = '{13'd1441, 13'd0,    16'd4096, 1'b0, 1440, 2};
        vecs[7]  = '{13'd1439, 13'd0,    16'd4096, 1'b0, 1408, 2};
        vecs[8]  = '{13'd10,   13'd0,    16'd4096, 1'b0, 10,   66};
        vecs[9]  = '{13'd2000, 13'd0,    16'd0,    1'b0, 0,    0};
        vecs[10] = '{13'd2000, 13'd0,    16'd5000, 1'b0, 0,    0};
        vecs[11] = '{13'd2000, 13'd8000, 16'd292,  1'b0, 96,   2};

        do_reset();
        chk("rst_trail", int'(trail_ptr), 0);
        chk("rst_val",   int'(seg_req_val), 0);
        chk("rst_ptr",   int'(seg_req_ptr), 0);
        chk("rst_size",  int'(seg_req_size), 0);

        for (int v = 0; v < 12; v++) begin
            do_reset();
            lead_ptr = vecs[v].lead;
            ack_ptr  = vecs[v].ack;
            peer_wnd = vecs[v].wnd;
            flush    = vecs[v].fl;
            wait_val(100, cyc, ok);
            if (vecs[v].exp_size == 0) begin
                chk($sformatf("v%0d_no_issue", v), int'(ok), 0);
            end else begin
                chk($sformatf("v%0d_val", v), int'(ok), 1);
                chk($sformatf("v%0d_lat", v), cyc, vecs[v].exp_lat);
                chk($sformatf("v%0d_ptr", v), int'(seg_req_ptr), 0);
                chk($sformatf("v%0d_size", v), int'(seg_req_size), vecs[v].exp_size);
                accept();
                chk($sformatf("v%0d_trail", v), int'(trail_ptr), vecs[v].exp_size);
                chk($sformatf("v%0d_val_drop", v), int'(seg_req_val), 0);
            end
        end

        // Full segment then coalesced 4-byte tail released by the timeout.
        do_reset();
        lead_ptr = 13'd100;
        wait_val(100, cyc, ok);
        chk("t1_lat", cyc, 2);
        chk("t1_size", int'(seg_req_size), 96);
        accept();
        chk("t1_trail", int'(trail_ptr), 96);
        wait_val(200, cyc, ok);
        chk("t1_hold_ok", int'(ok), 1);
        chk("t1_hold_cyc", cyc, 65);
        chk("t1_tail_ptr", int'(seg_req_ptr), 96);
        chk("t1_tail_size", int'(seg_req_size), 4);
        accept();
        chk("t1_trail_end", int'(trail_ptr), 100);

        // Large burst with rdy held high and ack tracking trail.
        do_reset();
        sizes = '{1440, 1440, 1440, 672, 8};
        exp_trail   = 0;
        seg_req_rdy = 1'b1;
        lead_ptr    = 13'd5000;
        for (int k = 0; k < 5; k++) begin
            wait_val(200, cyc, ok);
            chk($sformatf("t2_val%0d", k), int'(ok), 1);
            chk($sformatf("t2_ptr%0d", k), int'(seg_req_ptr), exp_trail);
            chk($sformatf("t2_size%0d", k), int'(seg_req_size), sizes[k]);
            @(posedge clk);
            #1;
            exp_trail = exp_trail + sizes[k];
            ack_ptr   = 13'(exp_trail);
            chk($sformatf("t2_trail%0d", k), int'(trail_ptr), exp_trail);
        end
        seg_req_rdy = 1'b0;

        // Window-limited pair of segments.
        do_reset();
        lead_ptr = 13'd2000;
        peer_wnd = 16'd100;
        wait_val(100, cyc, ok);
        chk("t3_size_a", int'(seg_req_size), 96);
        accept();
        ack_ptr = 13'd96;
        wait_val(100, cyc, ok);
        chk("t3_ptr_b", int'(seg_req_ptr), 96);
        chk("t3_size_b", int'(seg_req_size), 96);
        accept();
        chk("t3_trail", int'(trail_ptr), 192);

        // Segment crossing the buffer boundary.
        do_reset();
        ptr_load_val = 1'b1;
        ptr_load_ptr = 13'd8180;
        ack_ptr      = 13'd8180;
        lead_ptr     = 13'd20;
        @(posedge clk);
        #1;
        ptr_load_val = 1'b0;
        chk("t4_load", int'(trail_ptr), 8180);
        wait_val(100, cyc, ok);
        chk("t4_ptr", int'(seg_req_ptr), 8180);
        chk("t4_size", int'(seg_req_size), 32);
        accept();
        chk("t4_trail", int'(trail_ptr), 20);

        // Backpressure: descriptor frozen while lead keeps growing.
        do_reset();
        lead_ptr = 13'd100;
        wait_val(100, cyc, ok);
        p0 = int'(seg_req_ptr);
        s0 = int'(seg_req_size);
        chk("t5_size0", s0, 96);
        for (int k = 0; k < 10; k++) begin
            lead_ptr = lead_ptr + 13'd50;
            @(posedge clk);
            #1;
            if (k % 3 == 0) begin
                chk($sformatf("t5_val%0d", k), int'(seg_req_val), 1);
                chk($sformatf("t5_ptr%0d", k), int'(seg_req_ptr), p0);
                chk($sformatf("t5_size%0d", k), int'(seg_req_size), s0);
            end
        end
        accept();
        chk("t5_trail", int'(trail_ptr), 96);

        // Reload coincident with handshake voids it.
        do_reset();
        lead_ptr = 13'd100;
        wait_val(100, cyc, ok);
        seg_req_rdy  = 1'b1;
        ptr_load_val = 1'b1;
        ptr_load_ptr = 13'd40;
        @(posedge clk);
        #1;
        seg_req_rdy  = 1'b0;
        ptr_load_val = 1'b0;
        chk("t6_trail", int'(trail_ptr), 40);
        chk("t6_val", int'(seg_req_val), 0);
        wait_val(100, cyc, ok);
        chk("t6_ptr2", int'(seg_req_ptr), 40);
        chk("t6_size2", int'(seg_req_size), 32);

        // Async reset pulse while holding a tail.
        do_reset();
        ptr_load_val = 1'b1;
        ptr_load_ptr = 13'd500;
        ack_ptr      = 13'd500;
        lead_ptr     = 13'd600;
        @(posedge clk);
        #1;
        ptr_load_val = 1'b0;
        wait_val(100, cyc, ok);
        chk("t7_size", int'(seg_req_size), 96);
        accept();
        repeat (5) @(posedge clk);
        #1;
        chk("t7_hold_val", int'(seg_req_val), 0);
        chk("t7_hold_trail", int'(trail_ptr), 596);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_trail", int'(trail_ptr), 0);
        chk("t7_rst_val", int'(seg_req_val), 0);
        chk("t7_rst_ptr", int'(seg_req_ptr), 0);
        chk("t7_rst_size", int'(seg_req_size), 0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
